cache_arbiter: RTL
==================

# cache_arbiter

Shares the single physical-memory port between the I-cache and the D-cache controllers of the pipelined core. Each cache issues whole-line read or write requests with level handshakes, held until it sees its response. The arbiter grants one requester at a time using round-robin on ties, latches the granted request, and drives physical memory until its response. It then routes the response back and inserts one recovery cycle so the requester can drop its request.

## Interface
- ADDR_WIDTH, 32, byte address width of line requests
- LINE_WIDTH, 256, cache line width in bits

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low (asserted at 0); forces IDLE immediately
- i_pmem_read  input  1  I-cache line read request, level, held until i_pmem_resp
- i_pmem_address  input  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  output  LINE_WIDTH  line data to I-cache
- i_pmem_resp  output  1  one-cycle completion pulse to I-cache
- d_pmem_read  input  1  D-cache line read (allocate) request, level
- d_pmem_write  input  1  D-cache line write (write-back) request, level
- d_pmem_address  input  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  input  LINE_WIDTH  D-cache write-back line
- d_pmem_rdata  output  LINE_WIDTH  line data to D-cache
- d_pmem_resp  output  1  one-cycle completion pulse to D-cache
- pmem_read  output  1  memory read strobe, level
- pmem_write  output  1  memory write strobe, level
- pmem_address  output  ADDR_WIDTH  latched address of granted request
- pmem_wdata  output  LINE_WIDTH  latched write data of granted request
- pmem_rdata  input  LINE_WIDTH  memory read data, valid with pmem_resp
- pmem_resp  input  1  memory completion

## Operation
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- IDLE: if exactly one side requests, grant it. If both request, grant the side not recorded in last_grant. On grant:
  - latch address, wdata and op (read/write) into arbiter registers
  - update last_grant
  - go to SERVE_I or SERVE_D
- D-side op: if d_pmem_write and d_pmem_read are both high, write wins (write-back precedes allocate); read is not latched.
- SERVE_x: pmem_read or pmem_write equals the latched op, pmem_address and pmem_wdata equal the latched values. Stay until pmem_resp=1, then go to RECOVER.
- Response routing in the pmem_resp cycle:
  - x_pmem_resp = pmem_resp AND the granted side's request is still asserted
  - x_pmem_rdata = pmem_rdata (combinational pass-through)
  - the ungranted side's resp is 0
- Requester withdrawal mid-transfer: the memory transaction still runs to pmem_resp, using the latched values. The response is suppressed and is not delivered later.
- RECOVER: no strobes, no grant; unconditionally go to IDLE. This keeps a requester that is still high in its response cycle from causing a duplicate grant.
- i_pmem_rdata and d_pmem_rdata may always mirror pmem_rdata; they are only meaningful with the corresponding resp.

## Timing
- Reset (reset=0): state=IDLE, last_grant=D (first tie goes to I), latched address/wdata/op=0, pmem_read=pmem_write=0, i_pmem_resp=d_pmem_resp=0. Takes effect asynchronously, including mid-transfer.
- pmem_read, pmem_write, pmem_address and pmem_wdata are decoded from registered state and latches only, with no combinational path from requester inputs.
- Request seen high in IDLE at edge N: strobe high from after edge N.
- Memory pmem_resp high in cycle M: x_pmem_resp high in cycle M (same cycle), strobes low after edge M, RECOVER during cycle M+1, IDLE at M+2.
- Minimum spacing between two grants is 2 cycles after pmem_resp.
- A request arriving while another is being served waits; no preemption.
- Round-robin guarantees each side at most one foreign transaction of wait under continuous contention.

## Test plan
- Single I read: i_pmem_read=1, address 0x00000100; memory responds after 3 cycles with 0xAA..AA. Expect pmem_read=1 with address 0x100 for 4 cycles, i_pmem_resp=1 for one cycle with rdata 0xAA..AA, then RECOVER, IDLE, and no second pmem_read while i_pmem_read falls.
- Simultaneous I read and D write immediately after reset: I is granted first (last_grant reset=D). After I's resp+RECOVER, D write is issued with pmem_write=1, latched d_pmem_wdata, and D's address.
- Continuous contention, both sides always requesting: the grant sequence alternates I, D, I, D over 4 transactions.
- D write and D read both high, address 0x2000: pmem_write=1 with address 0x2000, pmem_read stays 0.
- I withdraws after 1 cycle of SERVE_I: pmem_read stays high until pmem_resp, i_pmem_resp stays 0, then RECOVER and IDLE.
- reset driven to 0 mid-SERVE_D: pmem_write drops to 0 without waiting for the clock; after release, the arbiter is IDLE and the first tie goes to I.

Source files
------------

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between I- and D-cache.
// One request is latched per grant; a recovery cycle follows every response.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RECOVER
    } state_t;

    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;
    logic serving;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                // On a tie last_d_q selects I, so the sides alternate.
                if (i_req && (!d_req || last_d_q)) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    op_d     = 1'b0;
                    addr_d   = i_pmem_address;
                    wdata_d  = '0;
                end else if (d_req) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    op_d     = d_pmem_write;
                    addr_d   = d_pmem_address;
                    wdata_d  = d_pmem_wdata;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_d = RECOVER;
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            op_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign pmem_read    = serving & ~op_q;
    assign pmem_write   = serving & op_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // A requester that withdrew mid-transfer gets no response.
    assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp & i_req;
    assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp & d_req;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
